// File: rtl/rv32imf_apu_result_queue.sv
// APU writeback buffer: in-order DEPTH-entry FIFO of {waddr, result, fflags} with
// zero-latency bypass when empty and per-register pending-write hazard detection.
module rv32imf_apu_result_queue #(
  parameter  int DEPTH   = 4,
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 6,
  parameter  int FLAGS_W = 5,
  parameter  int NQUERY  = 3,
  localparam int CNT_W   = $clog2(DEPTH+1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     apu_rvalid_i,
  input  logic [DATA_W-1:0]        apu_result_i,
  input  logic [FLAGS_W-1:0]       apu_flags_i,
  input  logic [ADDR_W-1:0]        apu_waddr_i,
  output logic                     apu_ready_o,
  input  logic                     wb_block_i,
  output logic                     wb_valid_o,
  output logic [ADDR_W-1:0]        wb_waddr_o,
  output logic [DATA_W-1:0]        wb_wdata_o,
  output logic [FLAGS_W-1:0]       wb_fflags_o,
  output logic                     wb_fflags_we_o,
  input  logic [NQUERY*ADDR_W-1:0] query_addr_i,
  input  logic [NQUERY-1:0]        query_valid_i,
  output logic [NQUERY-1:0]        hazard_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o
);

  typedef struct packed {
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  data;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic   empty, full, bypass, pop, push, ovf_set;
  entry_t in_ent;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ent = '{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i};

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Queued entries always win the port, so bypass only happens when empty.
  assign bypass  = ~flush_i & empty & ~wb_block_i & apu_rvalid_i;
  assign pop     = ~flush_i & ~empty & ~wb_block_i;
  assign push    = ~flush_i & apu_rvalid_i & ~bypass & (~full | pop);
  assign ovf_set = ~flush_i & apu_rvalid_i & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      // Pop before push: when full both pointers alias and the new entry must stay valid.
      if (pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= ptr_inc(rd_q);
      end
      if (push) begin
        mem_q[wr_q] <= in_ent;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= ptr_inc(wr_q);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    wb_valid_o  = 1'b0;
    wb_waddr_o  = '0;
    wb_wdata_o  = '0;
    wb_fflags_o = '0;
    if (pop) begin
      wb_valid_o  = 1'b1;
      wb_waddr_o  = mem_q[rd_q].waddr;
      wb_wdata_o  = mem_q[rd_q].data;
      wb_fflags_o = mem_q[rd_q].flags;
    end else if (bypass) begin
      wb_valid_o  = 1'b1;
      wb_waddr_o  = apu_waddr_i;
      wb_wdata_o  = apu_result_i;
      wb_fflags_o = apu_flags_i;
    end
  end

  for (genvar g = 0; g < NQUERY; g++) begin : g_query
    logic [ADDR_W-1:0] qa;
    logic              hit;
    assign qa = query_addr_i[g*ADDR_W +: ADDR_W];
    // Entry popped this cycle is still valid here; its write lands at the edge.
    always_comb begin
      hit = apu_rvalid_i && (apu_waddr_i == qa);
      for (int e = 0; e < DEPTH; e++)
        if (vld_q[e] && (mem_q[e].waddr == qa)) hit = 1'b1;
    end
    assign hazard_o[g] = query_valid_i[g] & hit;
  end

  assign wb_fflags_we_o = wb_valid_o;
  assign apu_ready_o    = ~full;
  assign count_o        = count_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign overflow_o     = ovf_q;

endmodule

// File: doc/rv32imf_apu_result_queue.md
Name: rv32imf_apu_result_queue

Overview:
- Parametrised APU writeback buffer for the RV32IMF EX stage.
- Replaces the single-entry APU result hold register with a DEPTH-entry in-order FIFO of {waddr, result, fflags}.
- Absorbs APU results while the writeback port is blocked by contention (LSU, MULH, misaligned, JALR); forwards them in order once unblocked.
- Provides per-register pending-write hazard detection to the decoder.

Parameters:
DEPTH, 4, number of buffered results; any value >= 1, not required to be a power of two
DATA_W, 32, result width
ADDR_W, 6, register-file write address width (covers the FP register file)
FLAGS_W, 5, fflags width
NQUERY, 3, number of hazard query ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of all entries and sticky state
apu_rvalid_i  in  1  APU result valid this cycle
apu_result_i  in  DATA_W  APU result
apu_flags_i  in  FLAGS_W  APU exception flags
apu_waddr_i  in  ADDR_W  destination register of the result
apu_ready_o  out  1  queue can accept a result (not full)
wb_block_i  in  1  writeback port unavailable this cycle
wb_valid_o  out  1  result presented to writeback
wb_waddr_o  out  ADDR_W  writeback address
wb_wdata_o  out  DATA_W  writeback data
wb_fflags_o  out  FLAGS_W  flags accompanying wb_wdata_o
wb_fflags_we_o  out  1  fflags write enable; equals wb_valid_o
query_addr_i  in  NQUERY*ADDR_W  register addresses to check
query_valid_i  in  NQUERY  per-query enable
hazard_o  out  NQUERY  query matches a pending write
count_o  out  $clog2(DEPTH+1)  occupied entries
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH
overflow_o  out  1  sticky: a result was pushed while full

Behaviour:
- Reset (async, rst_n=0): rd_ptr = wr_ptr = 0, count_o = 0, overflow_o = 0, all entry valid bits 0.
- Reset outputs: empty_o=1, full_o=0, apu_ready_o=1, wb_valid_o=0, wb_fflags_we_o=0, hazard_o=0, wb_waddr_o=0, wb_wdata_o=0, wb_fflags_o=0.
- Outputs are combinational from state and inputs; storage is registered.
- Bypass:
  - Condition: empty, wb_block_i=0, apu_rvalid_i=1.
  - Input appears on wb_* in the same cycle (zero latency); nothing is enqueued.
- Push:
  - Condition: apu_rvalid_i=1, bypass not taken, not full.
  - Entry written at wr_ptr; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Pop:
  - Condition: not empty, wb_block_i=0.
  - Head (rd_ptr) is driven on wb_*, wb_valid_o=1, rd_ptr advances with wrap.
  - When not empty, the head always takes priority over the input; there is no bypass past queued entries, so order is preserved.
- Simultaneous push and pop (non-empty): count unchanged, both pointers advance.
- Full:
  - With a pop in the same cycle, a push is accepted. apu_ready_o still reads 0 that cycle; it reflects the registered full state only.
  - Push while full with no pop: result dropped, overflow_o set to 1 at the next edge and held until flush_i or reset.
- Blocked and empty: wb_valid_o=0; any arriving result is enqueued.
- wb_* outputs when wb_valid_o=0: waddr, wdata and flags are 0.
- flush_i:
  - At the next edge, pointers, count, valid bits and overflow_o are cleared.
  - wb_valid_o is forced 0 in the flush cycle; any input that cycle is discarded.
  - flush_i has priority over push and pop.
- Hazard:
  - hazard_o[i] = query_valid_i[i] & (any valid entry with waddr == query_addr_i[i], or (apu_rvalid_i & apu_waddr_i == query_addr_i[i])).
  - An entry popped this cycle still counts (written at end of cycle).
- count_o width: $clog2(DEPTH+1); DEPTH=1 gives a 1-bit count.
- Reset mid-operation: all entries lost, no writeback issued, outputs at reset values immediately.

Test Plan:
- Reset, then apu_rvalid_i=1, result=0x3F800000, waddr=6'h21, wb_block_i=0 -> same cycle: wb_valid_o=1, wb_waddr_o=0x21, wb_wdata_o=0x3F800000; count_o stays 0.
- wb_block_i=1 for 3 cycles with results A (addr 0x22), B (0x23), C (0x24), then release -> count_o goes 1,2,3; wb outputs A, B, C on 3 consecutive cycles; empty_o=1 afterwards.
- DEPTH=4, block and push 5 results -> full_o=1 and apu_ready_o=0 after the 4th; 5th dropped; overflow_o=1 held; after release exactly 4 writebacks in order.
- Full queue, unblock and push same cycle -> head popped, new entry accepted, count_o stays 4, overflow_o remains 0.
- Queue holds addr 0x25; query_addr_i[0]=0x25, query_valid_i[0]=1 -> hazard_o[0]=1. query_addr_i[1]=0x05 -> hazard_o[1]=0. After that entry pops -> hazard_o[0]=0 the next cycle.
- Queue with 3 entries: flush_i=1 with apu_rvalid_i=1 -> wb_valid_o=0 that cycle; next cycle count_o=0, empty_o=1, overflow_o=0, no writeback.
